// File: rtl/mem_refill_arbiter_if.sv
// Requester and memory-side signals of the refill arbiter, one bundle per instance.
// master = arbiter view, slave = caches plus memory view.
interface mem_refill_arbiter_if #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4
);
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;

  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [LINE_W-1:0]    i_rdata;
  logic                 i_done;

  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [LINE_W-1:0]    d_rdata;
  logic                 d_done;

  logic                 mem_readM;
  logic                 mem_writeM;
  logic [WORD_SIZE-1:0] mem_address;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  logic                 busy;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_rdata, i_done, d_rdata, d_done,
           mem_readM, mem_writeM, mem_address, mem_wdata, busy
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_rdata, i_done, d_rdata, d_done,
           mem_readM, mem_writeM, mem_address, mem_wdata, busy
  );
endinterface

// File: rtl/mem_refill_arbiter.sv
// I/D refill arbiter: 4-word line reads (done at t+13) and single-word writes (done at t+3).
// Requests are level-held until done; define ARB_RR_EN for round-robin ties, else D wins.
module mem_refill_arbiter #(
  parameter int WORD_SIZE  = 16,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_refill_arbiter_if.master  bus
);
  localparam int LINE_W = WORD_SIZE * LINE_WORDS;
  localparam int WCNT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int LAT_W  = $clog2(MEM_LAT + 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;

  typedef struct packed {
    logic                 own_d;
    logic [WORD_SIZE-1:0] addr;
  } xfer_t;

  state_t               state;
  xfer_t                xfer;
  logic [WCNT_W-1:0]    wcnt;
  logic [WCNT_W-1:0]    wcnt_nxt;
  logic [LAT_W-1:0]     wait_cnt;
  logic [LINE_W-1:0]    line_buf;
  logic [LINE_W-1:0]    line_nxt;
  logic                 grant_d;
  logic                 grant_i;
  logic [WORD_SIZE-1:0] rd_base;
`ifdef ARB_RR_EN
  logic                 last_d;
`endif

  always_comb begin
`ifdef ARB_RR_EN
    grant_d = bus.d_req && (!bus.i_req || !last_d);
`else
    grant_d = bus.d_req;
`endif
    grant_i = bus.i_req && !grant_d;
  end

  assign rd_base  = (grant_d ? bus.d_addr : bus.i_addr) & ~WORD_SIZE'(LINE_WORDS - 1);
  assign wcnt_nxt = wcnt + WCNT_W'(1);

  always_comb begin
    line_nxt = line_buf;
    line_nxt[wcnt*WORD_SIZE +: WORD_SIZE] = bus.mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      xfer            <= '0;
      wcnt            <= '0;
      wait_cnt        <= '0;
      line_buf        <= '0;
      bus.i_rdata     <= '0;
      bus.i_done      <= 1'b0;
      bus.d_rdata     <= '0;
      bus.d_done      <= 1'b0;
      bus.mem_readM   <= 1'b0;
      bus.mem_writeM  <= 1'b0;
      bus.mem_address <= '0;
      bus.mem_wdata   <= '0;
      bus.busy        <= 1'b0;
`ifdef ARB_RR_EN
      last_d          <= 1'b1;
`endif
    end else begin
      bus.i_done     <= 1'b0;
      bus.d_done     <= 1'b0;
      bus.mem_readM  <= 1'b0;
      bus.mem_writeM <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d || grant_i) begin
            bus.busy   <= 1'b1;
            wcnt       <= '0;
            wait_cnt   <= '0;
            xfer.own_d <= grant_d;
`ifdef ARB_RR_EN
            // Only ties move the pointer, so alternation is between contested grants.
            if (bus.i_req && bus.d_req) last_d <= grant_d;
`endif
            if (grant_d && bus.d_we) begin
              xfer.addr       <= bus.d_addr;
              bus.mem_writeM  <= 1'b1;
              bus.mem_address <= bus.d_addr;
              bus.mem_wdata   <= bus.d_wdata;
              state           <= WR_REQ;
            end else begin
              xfer.addr       <= rd_base;
              bus.mem_readM   <= 1'b1;
              bus.mem_address <= rd_base;
              state           <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          wait_cnt <= '0;
          state    <= RD_WAIT;
        end
        RD_WAIT: begin
          if (wait_cnt == LAT_W'(MEM_LAT - 1)) begin
            line_buf <= line_nxt;
            if (wcnt == WCNT_W'(LINE_WORDS - 1)) begin
              state <= DONE;
              if (xfer.own_d) begin
                bus.d_done  <= 1'b1;
                bus.d_rdata <= line_nxt;
              end else begin
                bus.i_done  <= 1'b1;
                bus.i_rdata <= line_nxt;
              end
            end else begin
              wcnt            <= wcnt_nxt;
              bus.mem_readM   <= 1'b1;
              bus.mem_address <= xfer.addr + WORD_SIZE'(wcnt_nxt);
              state           <= RD_REQ;
            end
          end else begin
            wait_cnt <= wait_cnt + LAT_W'(1);
          end
        end
        WR_REQ: begin
          state <= WR_WAIT;
        end
        WR_WAIT: begin
          bus.d_done <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Directed bench for mem_refill_arbiter with a two-cycle word memory model.
module tb_mem_refill_arbiter;
  localparam int W  = 16;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_refill_arbiter_if #(.WORD_SIZE(W), .LINE_WORDS(LW)) mif();

  mem_refill_arbiter #(.WORD_SIZE(W), .LINE_WORDS(LW), .MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: data for a read strobe in cycle c is valid only in cycle c+2.
  logic [15:0] mem [0:255];
  logic        mem_init = 1'b0;
  logic        r1 = 1'b0, r2 = 1'b0;
  logic [15:0] a1 = 16'h0, a2 = 16'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    r1  <= mif.mem_readM;
    a1  <= mif.mem_address;
    r2  <= r1;
    a2  <= a1;
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= {i[7:0], ~i[7:0]};
      mem[8'h00] <= 16'h9023;
      mem[8'h01] <= 16'h0001;
      mem[8'h02] <= 16'hffff;
      mem[8'h24] <= 16'hf01c;
      mem[8'h25] <= 16'h6100;
      mem[8'h26] <= 16'hf41c;
      mem[8'h27] <= 16'h6200;
      mem_init   <= 1'b1;
    end else if (mif.mem_writeM) begin
      mem[mif.mem_address[7:0]] <= mif.mem_wdata;
    end
  end

  assign mif.mem_rdata = r2 ? mem[a2[7:0]] : 16'hdead;

  // Strobe monitor: exclusivity, spacing, and a log of read strobes.
  logic        prev_strobe = 1'b0;
  int          rd_cyc_q[$];
  logic [15:0] rd_addr_q[$];

  always @(negedge clk) begin
    if (mif.mem_readM || mif.mem_writeM)
      chk("strobe_sep", 64'({mif.mem_readM && mif.mem_writeM, prev_strobe}), 64'd0);
    if (mif.mem_readM) begin
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(mif.mem_address);
    end
    prev_strobe = mif.mem_readM || mif.mem_writeM;
  end

  typedef struct {
    logic        is_d;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [63:0] exp_line;
  } vec_t;

  vec_t vecs[8];

  localparam logic [63:0] LINE_24   = 64'h6200_f41c_6100_f01c;
  localparam logic [63:0] LINE_24W  = 64'h6200_f41c_1234_f01c;
  localparam logic [63:0] LINE_00   = 64'hbeef_ffff_0001_9023;
  localparam logic [63:0] LINE_40   = 64'h43bc_42bd_41be_40bf;
  localparam logic [63:0] LINE_FC   = 64'h0000_fe01_fd02_fc03;

  task automatic chk_zero(input string name);
    chk({name, "_ctl"}, 64'({mif.i_done, mif.d_done, mif.mem_readM, mif.mem_writeM, mif.busy}), 64'd0);
    chk({name, "_i_rdata"}, mif.i_rdata, 64'd0);
    chk({name, "_d_rdata"}, mif.d_rdata, 64'd0);
    chk({name, "_addr_wdata"}, 64'({mif.mem_address, mif.mem_wdata}), 64'd0);
  endtask

  task automatic run_txn(input logic is_d, input logic we, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [63:0] exp_line);
    logic [63:0] i_prev, d_prev;
    logic [15:0] base;
    int n, c0, exp_lat;
    logic seen;
    @(negedge clk);
    i_prev = mif.i_rdata;
    d_prev = mif.d_rdata;
    rd_cyc_q.delete();
    rd_addr_q.delete();
    c0   = cyc;
    base = addr & 16'hfffc;
    if (is_d) begin
      mif.d_req = 1'b1; mif.d_we = we; mif.d_addr = addr; mif.d_wdata = wdata;
    end else begin
      mif.i_req = 1'b1; mif.i_addr = addr;
    end
    exp_lat = (is_d && we) ? 3 : 13;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = is_d ? mif.d_done : mif.i_done;
    end
    mif.i_req = 1'b0;
    mif.d_req = 1'b0;
    chk("done_seen", 64'(seen), 64'd1);
    chk("latency", 64'(n), 64'(exp_lat));
    chk("busy_at_done", 64'(mif.busy), 64'd1);
    if (is_d && we) begin
      chk("wr_d_rdata_hold", mif.d_rdata, d_prev);
      chk("wr_no_reads", 64'(rd_addr_q.size()), 64'd0);
    end else begin
      chk("line", is_d ? mif.d_rdata : mif.i_rdata, exp_line);
      chk("other_hold", is_d ? mif.i_rdata : mif.d_rdata, is_d ? i_prev : d_prev);
      chk("rd_count", 64'(rd_addr_q.size()), 64'd4);
      if (rd_addr_q.size() == 4) begin
        chk("first_rd_cycle", 64'(rd_cyc_q[0] - c0), 64'd1);
        for (int k = 0; k < 4; k++) begin
          chk("rd_addr", 64'(rd_addr_q[k]), 64'(base + 16'(k)));
          chk("rd_spacing", 64'(rd_cyc_q[k] - rd_cyc_q[0]), 64'(3 * k));
        end
      end
    end
    @(negedge clk);
    chk("post_done_idle", 64'({mif.busy, mif.i_done, mif.d_done}), 64'd0);
  endtask

  task automatic tie_round(input logic exp_d_first);
    int n;
    logic seen_i, seen_d;
    @(negedge clk);
    mif.i_req = 1'b1; mif.i_addr = 16'h0041;
    mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_addr = 16'h00fe;
    seen_i = 1'b0; seen_d = 1'b0; n = 0;
    while (!seen_i && !seen_d && n < 40) begin
      @(negedge clk);
      n++;
      seen_i = mif.i_done;
      seen_d = mif.d_done;
    end
    chk("tie_first_lat", 64'(n), 64'd13);
    chk("tie_first_who", 64'({seen_d, seen_i}), exp_d_first ? 64'd2 : 64'd1);
    if (seen_d) mif.d_req = 1'b0;
    if (seen_i) mif.i_req = 1'b0;
    seen_i = 1'b0; seen_d = 1'b0; n = 0;
    while (!seen_i && !seen_d && n < 40) begin
      @(negedge clk);
      n++;
      seen_i = mif.i_done;
      seen_d = mif.d_done;
    end
    mif.i_req = 1'b0;
    mif.d_req = 1'b0;
    chk("tie_second_lat", 64'(n), 64'd14);
    chk("tie_second_who", 64'({seen_d, seen_i}), exp_d_first ? 64'd1 : 64'd2);
    chk("tie_i_line", mif.i_rdata, LINE_40);
    chk("tie_d_line", mif.d_rdata, LINE_FC);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, c1;
    logic seen, busy_ok, d_early;

    reset = 1'b1;
    mif.i_req = 1'b0; mif.i_addr = 16'h0;
    mif.d_req = 1'b0; mif.d_we = 1'b0; mif.d_addr = 16'h0; mif.d_wdata = 16'h0;

    vecs[0] = '{1'b0, 1'b0, 16'h0025, 16'h0000, LINE_24};
    vecs[1] = '{1'b1, 1'b1, 16'h0003, 16'hbeef, 64'd0};
    vecs[2] = '{1'b1, 1'b0, 16'h0000, 16'h0000, LINE_00};
    vecs[3] = '{1'b1, 1'b0, 16'h0026, 16'h0000, LINE_24};
    vecs[4] = '{1'b1, 1'b1, 16'h0025, 16'h1234, 64'd0};
    vecs[5] = '{1'b0, 1'b0, 16'h0027, 16'h0000, LINE_24W};
    vecs[6] = '{1'b0, 1'b0, 16'h0040, 16'h0000, LINE_40};
    vecs[7] = '{1'b1, 1'b1, 16'h00ff, 16'h0000, 64'd0};

    repeat (3) @(negedge clk);
    chk_zero("in_reset");
    reset = 1'b0;
    @(negedge clk);
    chk_zero("after_reset");

    for (int v = 0; v < 8; v++)
      run_txn(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].exp_line);
    run_txn(1'b1, 1'b0, 16'h00fd, 16'h0000, LINE_FC);

`ifdef ARB_RR_EN
    tie_round(1'b0);
    tie_round(1'b1);
`else
    tie_round(1'b1);
    tie_round(1'b1);
`endif

    // D held with d_we flipping at every done.
    @(negedge clk);
    mif.d_req = 1'b1; mif.d_we = 1'b1; mif.d_addr = 16'h0010; mif.d_wdata = 16'h0aaa;
    for (int k = 0; k < 4; k++) begin
      seen = 1'b0; n = 0;
      while (!seen && n < 40) begin
        @(negedge clk);
        n++;
        seen = mif.d_done;
      end
      chk("tog_done", 64'(seen), 64'd1);
      chk("tog_lat", 64'(n), (k == 0) ? 64'd3 : (mif.d_we ? 64'd4 : 64'd14));
      if (!mif.d_we)
        chk("tog_line", mif.d_rdata, (k == 1) ? 64'h13ec_12ed_11ee_0aaa : 64'h13ec_12ed_11ee_0bbb);
      if (k == 3) begin
        mif.d_req = 1'b0;
      end else begin
        mif.d_we    = ~mif.d_we;
        mif.d_wdata = 16'h0bbb;
      end
    end
    @(negedge clk);
    chk("tog_single_done", 64'(mif.d_done), 64'd0);

    // D arrives while an I line is in flight.
    @(negedge clk);
    mif.i_req = 1'b1; mif.i_addr = 16'h0042;
    seen = 1'b0; busy_ok = 1'b1; d_early = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 5) begin
        mif.d_req = 1'b1; mif.d_we = 1'b0; mif.d_addr = 16'h0001;
      end
      if (!mif.busy) busy_ok = 1'b0;
      if (mif.d_done) d_early = 1'b1;
      seen = mif.i_done;
    end
    mif.i_req = 1'b0;
    chk("ovl_i_lat", 64'(n), 64'd13);
    chk("ovl_busy", 64'({busy_ok, d_early}), 64'd2);
    chk("ovl_i_line", mif.i_rdata, LINE_40);
    rd_cyc_q.delete();
    rd_addr_q.delete();
    c1 = cyc;
    seen = 1'b0; n = 0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = mif.d_done;
    end
    mif.d_req = 1'b0;
    chk("ovl_d_lat", 64'(n), 64'd14);
    if (rd_cyc_q.size() > 0) chk("ovl_d_grant", 64'(rd_cyc_q[0] - c1), 64'd2);
    else chk("ovl_d_grant", 64'd0, 64'd2);
    chk("ovl_d_line", mif.d_rdata, LINE_00);
    chk("ovl_i_hold", mif.i_rdata, LINE_40);
    @(negedge clk);

    // Reset lands in the wait phase of word 2.
    @(negedge clk);
    rd_addr_q.delete();
    rd_cyc_q.delete();
    mif.i_req = 1'b1; mif.i_addr = 16'h0025;
    repeat (8) @(negedge clk);
    chk("pre_rst_words", 64'(rd_addr_q.size()), 64'd3);
    chk("pre_rst_busy", 64'(mif.busy), 64'd1);
    reset = 1'b1;
    mif.i_req = 1'b0;
    #1;
    chk_zero("mid_reset");
    repeat (2) @(negedge clk);
    chk_zero("mid_reset_hold");
    reset = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (mif.i_done || mif.d_done || mif.busy) seen = 1'b1;
    end
    chk("post_rst_quiet", 64'(seen), 64'd0);
    chk_zero("post_reset");
    run_txn(1'b0, 1'b0, 16'h0025, 16'h0000, LINE_24W);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
